// File: rtl/cmt_prog_ctrl.sv
// rtl/cmt_prog_ctrl.sv - serial programming sequencer for a bank of clock generators
module cmt_prog_ctrl #(
  parameter int N_CLK        = 4,
  parameter int CE_DELAY     = 4,
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_chan,
  input  logic [7:0]       req_m,
  input  logic [7:0]       req_d,
  input  logic             glbl_en,
  input  logic [N_CLK-1:0] progdone,
  output logic [N_CLK-1:0] progen,
  output logic             progdata,
  output logic [N_CLK-1:0] clk_en,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code,
  input  logic             err_clr,
  output logic             progdone_inv
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_D,
    S_GAP1,
    S_LOAD_M,
    S_GAP2,
    S_GO,
    S_WAIT_DONE
  } state_e;

  localparam logic [3:0]  CE_DELAY_W = 4'(CE_DELAY);
  localparam logic [4:0]  N_CLK_W    = 5'(N_CLK);
  localparam logic [15:0] WAIT_LAST  = 16'(DONE_TIMEOUT - 1);
  localparam logic [3:0]  LAST_BIT   = 4'd9;

  localparam logic [1:0] E_CHAN    = 2'b01;
  localparam logic [1:0] E_M_ZERO  = 2'b10;
  localparam logic [1:0] E_TIMEOUT = 2'b11;

  state_e             state_q, state_d;
  logic [3:0]         su_cnt_q;
  logic [3:0]         chan_q;
  logic [7:0]         m_q;
  logic [7:0]         d_q;
  logic [3:0]         bit_q;
  logic [15:0]        wcnt_q;
  logic [N_CLK-1:0]   mask_q;
  logic [N_CLK-1:0]   clk_en_q;
  logic               err_q;
  logic [1:0]         err_code_q;

  logic               startup_done;
  logic               accept;
  logic               chan_bad;
  logic               m_bad;
  logic               req_ok;
  logic [N_CLK-1:0]   chan_oh;
  logic [N_CLK-1:0]   req_oh;
  logic               done_sel;
  logic               done_ok;
  logic               timeout_hit;
  logic               new_err;
  logic [1:0]         new_code;
  logic [2:0]         bidx;

  assign startup_done = (su_cnt_q == CE_DELAY_W);
  assign req_ready    = (state_q == S_IDLE) && startup_done;
  assign busy         = ~req_ready;
  assign accept       = req_valid && req_ready;
  assign chan_bad     = ({1'b0, req_chan} >= N_CLK_W);
  assign m_bad        = (req_m == 8'd0);
  assign req_ok       = accept && !chan_bad && !m_bad;
  assign done_sel     = |(progdone & chan_oh);
  assign done_ok      = (state_q == S_WAIT_DONE) && (wcnt_q >= 16'd2) && done_sel;
  assign timeout_hit  = (state_q == S_WAIT_DONE) && (wcnt_q == WAIT_LAST);
  // Payload bits 0..7 sit at bit_q 2..9; the 3-bit wrap maps them onto 0..7.
  assign bidx         = bit_q[2:0] - 3'd2;
  assign progdone_inv = ~&progdone;
  assign clk_en       = clk_en_q;
  assign err          = err_q;
  assign err_code     = err_code_q;

  // One-hot decode of the latched channel and of the incoming request channel
  always_comb begin
    chan_oh = '0;
    req_oh  = '0;
    for (int i = 0; i < N_CLK; i++) begin
      chan_oh[i] = (chan_q == 4'(i));
      req_oh[i]  = (req_chan == 4'(i));
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed-length load phases, then wait for lock or timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (req_ok) state_d = S_LOAD_D;
      S_LOAD_D:    if (bit_q == LAST_BIT) state_d = S_GAP1;
      S_GAP1:      state_d = S_LOAD_M;
      S_LOAD_M:    if (bit_q == LAST_BIT) state_d = S_GAP2;
      S_GAP2:      state_d = S_GO;
      S_GO:        state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (done_ok || timeout_hit) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output logic: program enable for the latched channel and the serial bit
  always_comb begin
    progen   = '0;
    progdata = 1'b0;
    case (state_q)
      S_LOAD_D: begin
        progen = chan_oh;
        if (bit_q == 4'd0)      progdata = 1'b1;
        else if (bit_q == 4'd1) progdata = 1'b0;
        else                    progdata = d_q[bidx];
      end
      S_LOAD_M: begin
        progen = chan_oh;
        if (bit_q < 4'd2) progdata = 1'b1;
        else              progdata = m_q[bidx];
      end
      S_GO: begin
        progen = chan_oh;
      end
      default: begin
        progen   = '0;
        progdata = 1'b0;
      end
    endcase
  end

  // Startup counter: saturates at CE_DELAY to release the request port
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      su_cnt_q <= 4'd0;
    end else if (su_cnt_q != CE_DELAY_W) begin
      su_cnt_q <= su_cnt_q + 4'd1;
    end
  end

  // Request latch on a valid accept
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      chan_q <= 4'd0;
      m_q    <= 8'd0;
      d_q    <= 8'd0;
    end else if (req_ok) begin
      chan_q <= req_chan;
      m_q    <= req_m;
      d_q    <= req_d;
    end
  end

  // Bit counter within load phases and cycle counter within WAIT_DONE
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      bit_q  <= 4'd0;
      wcnt_q <= 16'd0;
    end else begin
      if ((state_q == S_LOAD_D || state_q == S_LOAD_M) && bit_q != LAST_BIT) begin
        bit_q <= bit_q + 4'd1;
      end else begin
        bit_q <= 4'd0;
      end
      if (state_q == S_WAIT_DONE) begin
        wcnt_q <= wcnt_q + 16'd1;
      end else begin
        wcnt_q <= 16'd0;
      end
    end
  end

  // Enable mask: a channel drops on accept and returns only after a good lock
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      mask_q <= '1;
    end else if (req_ok) begin
      mask_q <= mask_q & ~req_oh;
    end else if (done_ok) begin
      mask_q <= mask_q | chan_oh;
    end
  end

  // Registered clock enables gated by the global enable and startup
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      clk_en_q <= '0;
    end else begin
      clk_en_q <= mask_q & {N_CLK{glbl_en}} & {N_CLK{startup_done}};
    end
  end

  // Error detection: channel check beats zero multiplier; timeout loses to a late done
  always_comb begin
    new_err  = 1'b0;
    new_code = 2'b00;
    if (accept && chan_bad) begin
      new_err  = 1'b1;
      new_code = E_CHAN;
    end else if (accept && m_bad) begin
      new_err  = 1'b1;
      new_code = E_M_ZERO;
    end else if (timeout_hit && !done_ok) begin
      new_err  = 1'b1;
      new_code = E_TIMEOUT;
    end
  end

  // Sticky error: first code held until cleared; a clear coinciding with a new error records it
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else if (new_err) begin
      err_q <= 1'b1;
      if (!err_q || err_clr) begin
        err_code_q <= new_code;
      end
    end else if (err_clr) begin
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end
  end

endmodule

// File: tb/tb_cmt_prog_ctrl.sv
// tb/tb_cmt_prog_ctrl.sv - directed self-checking bench for cmt_prog_ctrl
module tb_cmt_prog_ctrl;

  logic       CLK;
  logic       RESET_N;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_chan;
  logic [7:0] req_m;
  logic [7:0] req_d;
  logic       glbl_en;
  logic [3:0] progdone;
  logic [3:0] progen;
  logic       progdata;
  logic [3:0] clk_en;
  logic       busy;
  logic       err;
  logic [1:0] err_code;
  logic       err_clr;
  logic       progdone_inv;

  int checks;
  int failures;

  cmt_prog_ctrl #(
    .N_CLK(4),
    .CE_DELAY(4),
    .DONE_TIMEOUT(8)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_chan(req_chan),
    .req_m(req_m),
    .req_d(req_d),
    .glbl_en(glbl_en),
    .progdone(progdone),
    .progen(progen),
    .progdata(progdata),
    .clk_en(clk_en),
    .busy(busy),
    .err(err),
    .err_code(err_code),
    .err_clr(err_clr),
    .progdone_inv(progdone_inv)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [7:0] m, input logic [7:0] d);
    int n;
    req_chan  = c;
    req_m     = m;
    req_d     = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready got=%b exp=1", req_ready);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL wait_idle got=%b exp=1", req_ready);
    end
  endtask

  task automatic check_startup(input string tag);
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (req_ready !== (k >= 4)) begin
        failures++;
        $display("FAIL %s_ready edge=%0d got=%b exp=%b", tag, k, req_ready, (k >= 4));
      end
      checks++;
      if (clk_en !== ((k >= 5) ? 4'hF : 4'h0)) begin
        failures++;
        $display("FAIL %s_clk_en edge=%0d got=%h exp=%h", tag, k, clk_en, ((k >= 5) ? 4'hF : 4'h0));
      end
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; glbl_en = 1'b1; req_valid = 1'b0; req_chan = 4'd0;
    req_m = 8'd0; req_d = 8'd0; progdone = 4'h0; err_clr = 1'b0;
    step(); step(); step();
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", busy); end
    checks++; if (progen !== 4'h0) begin failures++; $display("FAIL rst_progen got=%h exp=0", progen); end
    checks++; if (progdata !== 1'b0) begin failures++; $display("FAIL rst_progdata got=%b exp=0", progdata); end
    checks++; if (clk_en !== 4'h0) begin failures++; $display("FAIL rst_clk_en got=%h exp=0", clk_en); end
    checks++; if (err !== 1'b0 || err_code !== 2'b00) begin failures++; $display("FAIL rst_err got=%b/%b exp=0/00", err, err_code); end
    checks++; if (progdone_inv !== 1'b1) begin failures++; $display("FAIL rst_progdone_inv got=%b exp=1", progdone_inv); end
    RESET_N = 1'b1;
    check_startup("startup");
  endtask

  task automatic test_program();
    logic [0:22] exp_data;
    logic [0:22] exp_en;
    exp_data = 23'b1001000000_0_1111010000_0_0;
    exp_en   = 23'b1111111111_0_1111111111_0_1;
    progdone = 4'h0;
    issue(4'd2, 8'h0B, 8'h02);
    for (int i = 0; i < 23; i++) begin
      checks++;
      if (progen !== (exp_en[i] ? 4'b0100 : 4'b0000)) begin
        failures++;
        $display("FAIL prog_progen cyc=%0d got=%b exp=%b", i, progen, (exp_en[i] ? 4'b0100 : 4'b0000));
      end
      checks++;
      if (progdata !== exp_data[i]) begin
        failures++;
        $display("FAIL prog_progdata cyc=%0d got=%b exp=%b", i, progdata, exp_data[i]);
      end
      checks++;
      if (clk_en !== ((i == 0) ? 4'hF : 4'b1011)) begin
        failures++;
        $display("FAIL prog_clk_en cyc=%0d got=%b exp=%b", i, clk_en, ((i == 0) ? 4'hF : 4'b1011));
      end
      step();
    end
    checks++; if (progen !== 4'h0 || busy !== 1'b1) begin failures++; $display("FAIL prog_wait_entry got=%b/%b exp=0000/1", progen, busy); end
    progdone = 4'b0100;
    step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL prog_ignore1 got=%b exp=1", busy); end
    step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL prog_ignore2 got=%b exp=1", busy); end
    step();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL prog_done_idle got=%b exp=1", req_ready); end
    checks++; if (clk_en !== 4'b1011) begin failures++; $display("FAIL prog_done_ce_lag got=%b exp=1011", clk_en); end
    step();
    checks++; if (clk_en !== 4'hF) begin failures++; $display("FAIL prog_done_ce got=%b exp=1111", clk_en); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL prog_no_err got=%b exp=0", err); end
    progdone = 4'h0;
  endtask

  task automatic test_invalid();
    issue(4'd5, 8'h01, 8'h01);
    checks++; if (err !== 1'b1 || err_code !== 2'b01) begin failures++; $display("FAIL inv_chan got=%b/%b exp=1/01", err, err_code); end
    checks++; if (progen !== 4'h0 || req_ready !== 1'b1) begin failures++; $display("FAIL inv_chan_idle got=%b/%b exp=0000/1", progen, req_ready); end
    step();
    checks++; if (progen !== 4'h0) begin failures++; $display("FAIL inv_chan_noprog got=%b exp=0000", progen); end
    issue(4'd1, 8'h00, 8'h00);
    checks++; if (err !== 1'b1 || err_code !== 2'b01) begin failures++; $display("FAIL inv_sticky got=%b/%b exp=1/01", err, err_code); end
    checks++; if (progen !== 4'h0 || clk_en !== 4'hF) begin failures++; $display("FAIL inv_m_noprog got=%b/%b exp=0000/1111", progen, clk_en); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++; if (err !== 1'b0 || err_code !== 2'b00) begin failures++; $display("FAIL inv_clear got=%b/%b exp=0/00", err, err_code); end
    issue(4'd7, 8'h01, 8'h01);
    checks++; if (err_code !== 2'b01) begin failures++; $display("FAIL inv_chan7 got=%b exp=01", err_code); end
    err_clr = 1'b1;
    issue(4'd0, 8'h00, 8'h00);
    err_clr = 1'b0;
    checks++; if (err !== 1'b1 || err_code !== 2'b10) begin failures++; $display("FAIL inv_clr_coincide got=%b/%b exp=1/10", err, err_code); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++; if (err !== 1'b0 || err_code !== 2'b00) begin failures++; $display("FAIL inv_clear2 got=%b/%b exp=0/00", err, err_code); end
  endtask

  task automatic test_timeout();
    progdone = 4'h0;
    issue(4'd1, 8'h03, 8'h04);
    for (int i = 0; i < 30; i++) step();
    checks++; if (busy !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL to_last_wait got=%b/%b exp=1/0", busy, err); end
    step();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL to_idle got=%b exp=1", req_ready); end
    checks++; if (err !== 1'b1 || err_code !== 2'b11) begin failures++; $display("FAIL to_code got=%b/%b exp=1/11", err, err_code); end
    checks++; if (clk_en !== 4'b1101) begin failures++; $display("FAIL to_ce got=%b exp=1101", clk_en); end
    step(); step();
    checks++; if (clk_en !== 4'b1101) begin failures++; $display("FAIL to_ce_hold got=%b exp=1101", clk_en); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    progdone = 4'b0010;
    issue(4'd1, 8'h03, 8'h04);
    wait_idle();
    step();
    checks++; if (clk_en !== 4'hF) begin failures++; $display("FAIL to_reprog_ce got=%b exp=1111", clk_en); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_reprog_err got=%b exp=0", err); end
    progdone = 4'h0;
  endtask

  task automatic test_glbl_en();
    progdone = 4'hF;
    #1;
    checks++; if (progdone_inv !== 1'b0) begin failures++; $display("FAIL ge_progdone_inv got=%b exp=0", progdone_inv); end
    progdone = 4'h0;
    glbl_en = 1'b0;
    #1;
    checks++; if (clk_en !== 4'hF) begin failures++; $display("FAIL ge_lag got=%b exp=1111", clk_en); end
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (clk_en !== 4'h0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL ge_low cyc=%0d got=%b/%b exp=0000/1", k, clk_en, req_ready);
      end
    end
    glbl_en = 1'b1;
    step();
    checks++; if (clk_en !== 4'hF) begin failures++; $display("FAIL ge_restore got=%b exp=1111", clk_en); end
  endtask

  task automatic test_reset_mid();
    progdone = 4'b0001;
    issue(4'd0, 8'h05, 8'h06);
    for (int i = 0; i < 13; i++) step();
    checks++; if (progen !== 4'b0001 || progdata !== 1'b1) begin failures++; $display("FAIL rm_load_m got=%b/%b exp=0001/1", progen, progdata); end
    RESET_N = 1'b0;
    step();
    checks++; if (progen !== 4'h0 || progdata !== 1'b0) begin failures++; $display("FAIL rm_abort got=%b/%b exp=0000/0", progen, progdata); end
    checks++; if (clk_en !== 4'h0 || req_ready !== 1'b0) begin failures++; $display("FAIL rm_state got=%b/%b exp=0000/0", clk_en, req_ready); end
    progdone = 4'h0;
    RESET_N = 1'b1;
    check_startup("restart");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_program();
    test_invalid();
    test_timeout();
    test_glbl_en();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmt_prog_ctrl.md
CMT_PROG_CTRL -- requirements
Module: cmt_prog_ctrl

Interface
REQ-001 SHALL have parameter N_CLK, default 4: number of programmable clock generators, range 1..16.
REQ-002 SHALL have parameter CE_DELAY, default 4: cycles after reset release before any clock enable asserts, range 1..15.
REQ-003 SHALL have parameter DONE_TIMEOUT, default 1023: maximum WAIT_DONE cycles, range 4..65535.
REQ-004 SHALL have port CLK  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port RESET_N  in  1  synchronous reset, active-low.
REQ-006 SHALL have port req_valid  in  1  programming request present.
REQ-007 SHALL have port req_ready  out  1  request accepted when req_valid & req_ready at a rising edge.
REQ-008 SHALL have port req_chan  in  4  target generator index.
REQ-009 SHALL have port req_m  in  8  multiplier minus one (M-1).
REQ-010 SHALL have port req_d  in  8  divider minus one (D-1).
REQ-011 SHALL have port glbl_en  in  1  global clock enable.
REQ-012 SHALL have port progdone  in  N_CLK  per-generator done flags.
REQ-013 SHALL have port progen  out  N_CLK  per-generator program enable.
REQ-014 SHALL have port progdata  out  1  shared serial program data.
REQ-015 SHALL have port clk_en  out  N_CLK  per-generator clock enable (CE of output buffers).
REQ-016 SHALL have ports busy  out  1, err  out  1, err_code  out  2, err_clr  in  1.
REQ-017 SHALL have port progdone_inv  out  1, combinational ~&progdone.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD_D, GAP1, LOAD_M, GAP2, GO, WAIT_DONE.
REQ-019 SHALL drive req_ready=1 only in IDLE with startup counter expired; busy = ~req_ready.
REQ-020 SHALL validate on acceptance: req_chan>=N_CLK -> err_code 01; req_m==0 -> err_code 10 (chan check wins); an invalid request completes its handshake, stays in IDLE, and drives no progen.
REQ-021 SHALL on a valid accept at edge t latch chan/M-1/D-1, clear clk_en[chan] at edge t+1, and enter LOAD_D.
REQ-022 SHALL in LOAD_D hold progen[chan]=1 for exactly 10 cycles with progdata = 1, 0, then D-1 bits 0..7 LSB first.
REQ-023 SHALL in GAP1 and GAP2 hold all progen=0, progdata=0, for exactly 1 cycle each.
REQ-024 SHALL in LOAD_M hold progen[chan]=1 for 10 cycles with progdata = 1, 1, then M-1 bits 0..7 LSB first.
REQ-025 SHALL in GO hold progen[chan]=1, progdata=0, for exactly 1 cycle; the total accept-to-WAIT_DONE latency is 23 cycles.
REQ-026 SHALL in WAIT_DONE ignore progdone for the first 2 cycles, then return to IDLE on the first cycle progdone[chan]=1 and re-enable clk_en[chan] on the following edge.
REQ-027 SHALL, if progdone[chan] is not seen within DONE_TIMEOUT cycles of WAIT_DONE entry, set err_code 11, return to IDLE, and keep clk_en[chan] low until that channel is successfully reprogrammed.
REQ-028 SHALL never assert more than one progen bit at a time; progen bits of other channels stay 0.
REQ-029 SHALL register clk_en = enable_mask & {N_CLK{glbl_en}} & startup_done, with 1-cycle latency from glbl_en.
REQ-030 SHALL make err sticky: it sets on any error, and err_code keeps the first error until err_clr; when err_clr and a new error coincide, the new error is recorded.
REQ-031 SHALL ignore req_valid while not in IDLE; the request stays pending under valid/ready rules.

Reset
REQ-032 SHALL, while RESET_N=0 at an edge, force state IDLE, progen=0, progdata=0, clk_en=0, err=0, err_code=00, enable_mask all ones, and startup counter 0.
REQ-033 SHALL, after RESET_N rises, assert startup_done and req_ready after CE_DELAY edges; clk_en follows 1 cycle later if glbl_en=1.
REQ-034 SHALL abort immediately on reset mid-programming, dropping progen to 0 at the same edge.

Verification
REQ-035 SHALL verify startup with N_CLK=4, CE_DELAY=4, glbl_en=1: release reset -> req_ready at edge 4 and clk_en=4'hF at edge 5.
REQ-036 SHALL verify programming chan=2, M-1=0x0B, D-1=0x02 with progdone[2]=1 -> progen=4'b0100 with serial stream 1,0,0,1,0,0,0,0,0,0 | gap | 1,1,1,1,0,1,0,0,0,0 | gap | GO, and clk_en[2] low from t+1 until 1 cycle after done.
REQ-037 SHALL verify invalid requests: chan=5 -> err=1, code 01, no progen; then M-1=0 without err_clr -> code stays 01.
REQ-038 SHALL verify timeout with progdone[1] held 0 and DONE_TIMEOUT=8 -> code 11, IDLE, clk_en[1]=0 while the other channels stay 1.
REQ-039 SHALL verify reset applied during LOAD_M -> progen=0 at that edge and the full startup sequence repeats.
REQ-040 SHALL verify that glbl_en dropping for 3 cycles -> clk_en=0 for exactly those 3 cycles delayed by 1, with FSM state unaffected.
